// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared constants and helpers for the slide-switch debouncer.
//   SW_WIDTH         : default number of switch bits
//   DEB_TICK_DIV     : default clock cycles per debounce tick (1 ms at 50 MHz)
//   DEB_STABLE_TICKS : default disagreeing ticks needed to commit a change
//   cnt_width(n)     : bits needed to hold values 0..n
package debounce_pkg;

  localparam int SW_WIDTH         = 12;
  localparam int DEB_TICK_DIV     = 50000;
  localparam int DEB_STABLE_TICKS = 10;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell
// One switch bit's stability filter. The output level only follows the
// synchronized input after it has disagreed for STABLE_TICKS ticks in a row;
// any agreeing cycle restarts the window.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   tick       : one-cycle prescaler strobe shared by all bits
//   sync_bit   : synchronized switch level
//   level      : debounced level
//   changed    : registered one-cycle pulse on the cycle level updates
//   commit     : combinational "level updates on this edge" strobe, used by
//                the parent to register its aggregate pulse alongside changed
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sync_bit,
  output logic level,
  output logic changed,
  output logic commit
);

  localparam int            CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          level_next;
  logic          commit_next;

  always_comb begin
    cnt_next    = cnt;
    level_next  = level;
    commit_next = 1'b0;
    if (sync_bit == level) begin
      // Agreement (including bounce back) discards any partial window.
      cnt_next = '0;
    end else if (tick && (cnt == LAST)) begin
      level_next  = sync_bit;
      cnt_next    = '0;
      commit_next = 1'b1;
    end else if (tick) begin
      cnt_next = cnt + CW'(1);
    end
  end

  assign commit = commit_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      level   <= 1'b0;
      changed <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      level   <= level_next;
      changed <= commit_next;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce
// Conditions raw slide switches for the switch PIO: two-flop synchronizer per
// bit, one shared tick prescaler, and a per-bit stability filter.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   sw_in      : raw asynchronous switch levels
//   sw_out     : debounced levels (to PIO in_port)
//   sw_changed : one-cycle pulse per bit when its sw_out bit updates
//   any_change : OR of sw_changed, asserted in the same cycle
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = DEB_TICK_DIV,
  parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PW-1:0]    pre;
  logic             tick;
  logic [WIDTH-1:0] commit;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      pre        <= '0;
      any_change <= 1'b0;
    end else begin
      sync1      <= sw_in;
      sync2      <= sync1;
      pre        <= tick ? '0 : pre + PW'(1);
      // Registered from the cells' commit strobes so it lines up with sw_changed.
      any_change <= |commit;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      debounce_cell #(
        .STABLE_TICKS(STABLE_TICKS)
      ) u_cell (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .sync_bit(sync2[gi]),
        .level   (sw_out[gi]),
        .changed (sw_changed[gi]),
        .commit  (commit[gi])
      );
    end
  endgenerate

endmodule
